rtc_bus_sequencer: RTL and testbench

Parametrised bus engine for the multiplexed address/data RTC interface (a_d, cs, rd, wr, dato). It performs periodic and on-demand read bursts of NREG consecutive RTC registers, and masked write bursts. Read results are published atomically, so the display and control logic never see a torn time or date. It sits between the RTC control FSM (time/date/timer editing) and the pad-level tristate on dato.

---
 rtl/rtc_bus_pkg.sv | 35 +++
 rtl/rtc_phase_timer.sv | 21 ++
 rtl/rtc_bus_sequencer.sv | 141 ++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC bus sequencer: FSM states and the per-phase strobe decode.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR_STB, ADDR_REL, DATA_STB, DATA_REL, NEXT, DONE
  } state_t;

  typedef struct packed {
    logic a_d;
    logic cs;
    logic rd;
    logic wr;
    logic oe;
  } strobe_t;

  localparam strobe_t STB_IDLE = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0};

  // The address is latched by the RTC on a wr strobe, so ADDR_STB pulls wr low even for reads.
  function automatic strobe_t phase_strobes(state_t st, logic is_wr);
    strobe_t s;
    s = STB_IDLE;
    case (st)
      ADDR_STB: begin s.a_d = 1'b0; s.cs = 1'b0; s.wr = 1'b0; s.oe = 1'b1; end
      ADDR_REL: begin s.a_d = 1'b0; s.oe = 1'b1; end
      DATA_STB: begin
        s.cs = 1'b0;
        if (is_wr) begin s.wr = 1'b0; s.oe = 1'b1; end
        else s.rd = 1'b0;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Wrapping cycle counter: phase_end marks the last cycle of each LEN-cycle period.
module rtc_phase_timer #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic phase_end
);
  localparam int W = (LEN > 1) ? $clog2(LEN) : 1;

  logic [W-1:0] cnt;

  assign phase_end = en && (cnt == W'(LEN - 1));

  always_ff @(posedge clk) begin
    if (reset || restart) cnt <= '0;
    else if (en)          cnt <= phase_end ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data RTC bus engine: read bursts (on demand or periodic) and masked
// write bursts, with read results published atomically on rd_valid.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int          NREG        = 9,
  parameter int          BUS_W       = 8,
  parameter int unsigned BASE_ADDR   = 'h21,
  parameter int          T_PHASE     = 4,
  parameter int          REFRESH_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_req,
  input  logic                    wr_req,
  input  logic [NREG*BUS_W-1:0]   wr_data,
  input  logic [NREG-1:0]         wr_mask,
  input  logic [BUS_W-1:0]        dato_in,
  output logic [BUS_W-1:0]        dato_out,
  output logic                    dato_oe,
  output logic                    a_d,
  output logic                    cs,
  output logic                    rd,
  output logic                    wr,
  output logic                    busy,
  output logic [NREG*BUS_W-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    wr_done
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t                         state;
  strobe_t                        stb;
  logic [IW-1:0]                  idx, nidx;
  logic                           wr_mode, rd_pend, wr_pend;
  logic                           in_phase, ph_end, ref_end;
  logic [NREG-1:0][BUS_W-1:0]     wr_shadow, rd_shadow;
  logic [NREG-1:0]                mask_shadow;

  function automatic logic [BUS_W-1:0] addr_of(input logic [IW-1:0] i);
    return BUS_W'(BASE_ADDR + 32'(i));
  endfunction

  assign in_phase = state inside {ADDR_STB, ADDR_REL, DATA_STB, DATA_REL};
  assign nidx     = idx + 1'b1;
  assign {a_d, cs, rd, wr, dato_oe} = stb;

  rtc_phase_timer #(.LEN(T_PHASE)) u_phase (
    .clk(clk), .reset(reset), .restart(!in_phase), .en(in_phase), .phase_end(ph_end)
  );

  // Free-running refresh; a zero period disables it.
  rtc_phase_timer #(.LEN((REFRESH_CYC > 0) ? REFRESH_CYC : 1)) u_refresh (
    .clk(clk), .reset(reset), .restart(1'b0), .en(REFRESH_CYC != 0), .phase_end(ref_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      stb         <= STB_IDLE;
      dato_out    <= '0;
      idx         <= '0;
      wr_mode     <= 1'b0;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      wr_done     <= 1'b0;
      rd_data     <= '0;
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      rd_shadow   <= '0;
      wr_shadow   <= '0;
      mask_shadow <= '0;
    end else begin
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      if (wr_req) begin
        wr_shadow   <= wr_data;
        mask_shadow <= wr_mask;
      end

      case (state)
        IDLE: if (wr_pend || rd_pend) begin
          wr_mode <= wr_pend;
          idx     <= '0;
          busy    <= 1'b1;
          if (wr_pend && !mask_shadow[0]) begin
            state <= NEXT;
          end else begin
            state    <= ADDR_STB;
            stb      <= phase_strobes(ADDR_STB, wr_pend);
            dato_out <= addr_of('0);
          end
        end
        ADDR_STB: if (ph_end) begin
          state <= ADDR_REL;
          stb   <= phase_strobes(ADDR_REL, wr_mode);
        end
        ADDR_REL: if (ph_end) begin
          state    <= DATA_STB;
          stb      <= phase_strobes(DATA_STB, wr_mode);
          dato_out <= wr_mode ? wr_shadow[idx] : '0;
        end
        DATA_STB: if (ph_end) begin
          state    <= DATA_REL;
          stb      <= STB_IDLE;
          dato_out <= '0;
          if (!wr_mode) rd_shadow[idx] <= dato_in;
        end
        DATA_REL: if (ph_end) state <= NEXT;
        NEXT: begin
          if (idx == IW'(NREG - 1)) begin
            state <= DONE;
            if (wr_mode) wr_done <= 1'b1;
            else begin
              rd_valid <= 1'b1;
              rd_data  <= rd_shadow;
            end
          end else begin
            idx <= nidx;
            if (!wr_mode || mask_shadow[nidx]) begin
              state    <= ADDR_STB;
              stb      <= phase_strobes(ADDR_STB, wr_mode);
              dato_out <= addr_of(nidx);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // A request landing on the cycle its flag is consumed stays pending for the next burst.
      if (wr_req)                                 wr_pend <= 1'b1;
      else if (state == IDLE && wr_pend)          wr_pend <= 1'b0;
      if (rd_req || ref_end)                      rd_pend <= 1'b1;
      else if (state == IDLE && !wr_pend && rd_pend) rd_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: burst-waveform model checked every cycle plus directed literal checks.
module tb_rtc_bus_sequencer;
  localparam int NREG = 3, BUS_W = 8, BASE = 'h21, TP = 2, REF = 50;

  logic clk = 1'b0, reset = 1'b1, rd_req = 1'b0, wr_req = 1'b0;
  logic [NREG*BUS_W-1:0] wr_data = '0, rd_data;
  logic [NREG-1:0]       wr_mask = '0;
  logic [BUS_W-1:0]      dato_in, dato_out;
  logic dato_oe, a_d, cs, rd, wr, busy, rd_valid, wr_done;
  int cyc = 0, errors = 0, checks = 0;

  rtc_bus_sequencer #(.NREG(NREG), .BUS_W(BUS_W), .BASE_ADDR(BASE), .T_PHASE(TP), .REFRESH_CYC(REF)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data), .wr_mask(wr_mask),
    .dato_in(dato_in), .dato_out(dato_out), .dato_oe(dato_oe), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .wr_done(wr_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC device: latches the address on the address strobe, answers reads from a fixed table.
  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    case (a)
      8'h21:   return 8'h45;
      8'h22:   return 8'h30;
      8'h23:   return 8'h12;
      default: return 8'hEE;
    endcase
  endfunction
  logic [7:0] rtc_addr = '0;
  always @(posedge clk) if (!cs && !a_d) rtc_addr <= dato_out;
  assign dato_in = (!cs && !rd) ? rtc_val(rtc_addr) : 8'hEE;

  // Model: each burst is expanded into its expected cycle-by-cycle bus waveform.
  typedef struct packed {
    logic a_d, cs, rd, wr, oe;
    logic [7:0] dout;
    logic busy, rv, wd;
  } exp_t;
  localparam exp_t E_IDLE = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0, dout: 8'h00,
                              busy: 1'b0, rv: 1'b0, wd: 1'b0};
  exp_t exp_q[$];
  exp_t m_exp = E_IDLE;
  logic m_on = 1'b0, m_idle = 1'b1, m_rd_pend = 1'b0, m_wr_pend = 1'b0;
  int   m_ref = 0;
  logic [NREG*BUS_W-1:0] m_wdata = '0, m_rd_data = '0;
  logic [NREG-1:0]       m_mask = '0;

  task automatic push_n(input exp_t e, input int n);
    for (int c = 0; c < n; c++) exp_q.push_back(e);
  endtask

  task automatic build_burst(input bit is_wr);
    exp_t b, e;
    b = E_IDLE; b.busy = 1'b1;
    for (int j = 0; j < NREG; j++) begin
      if (!is_wr || m_mask[j]) begin
        e = b; e.a_d = 1'b0; e.cs = 1'b0; e.wr = 1'b0; e.oe = 1'b1; e.dout = 8'(BASE + j);
        push_n(e, TP);
        e.cs = 1'b1; e.wr = 1'b1;
        push_n(e, TP);
        e = b; e.cs = 1'b0;
        if (is_wr) begin e.wr = 1'b0; e.oe = 1'b1; e.dout = m_wdata[j*BUS_W +: BUS_W]; end
        else e.rd = 1'b0;
        push_n(e, TP);
        push_n(b, TP);
      end
      push_n(b, 1);
    end
    e = b;
    if (is_wr) e.wd = 1'b1; else e.rv = 1'b1;
    push_n(e, 1);
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_rd_pend = 1'b0; m_wr_pend = 1'b0; m_ref = 0; m_rd_data = '0;
      m_idle = 1'b1; m_exp = E_IDLE; m_on = 1'b1;
    end else begin
      if (m_idle && m_wr_pend)      begin m_wr_pend = 1'b0; build_burst(1'b1); end
      else if (m_idle && m_rd_pend) begin m_rd_pend = 1'b0; build_burst(1'b0); end
      if (rd_req || m_ref == REF - 1) m_rd_pend = 1'b1;
      m_ref = (m_ref == REF - 1) ? 0 : m_ref + 1;
      if (wr_req) begin m_wr_pend = 1'b1; m_wdata = wr_data; m_mask = wr_mask; end
      if (exp_q.size() > 0) begin
        m_exp  = exp_q.pop_front();
        m_idle = 1'b0;
        if (m_exp.rv)
          for (int j = 0; j < NREG; j++) m_rd_data[j*BUS_W +: BUS_W] = rtc_val(8'(BASE + j));
      end else begin
        m_exp  = E_IDLE;
        m_idle = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model, plus an event log for the directed checks.
  int astb_cyc[$], rv_cyc[$], wd_cyc[$];
  logic [7:0] astb_addr[$], wstb_data[$];
  logic p_cs = 1'b1, p_wr = 1'b1;

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      checks++;
      if ({a_d, cs, rd, wr, dato_oe, busy, rd_valid, wr_done} !==
          {m_exp.a_d, m_exp.cs, m_exp.rd, m_exp.wr, m_exp.oe, m_exp.busy, m_exp.rv, m_exp.wd} ||
          (m_exp.oe && dato_out !== m_exp.dout) || rd_data !== m_rd_data) begin
        errors++;
        $display("FAIL model cyc=%0d ad/cs/rd/wr/oe/busy/rv/wd=%b%b%b%b%b%b%b%b dout=%h rd_data=%h required=%b%b%b%b%b%b%b%b dout=%h rd_data=%h",
                 cyc, a_d, cs, rd, wr, dato_oe, busy, rd_valid, wr_done, dato_out, rd_data,
                 m_exp.a_d, m_exp.cs, m_exp.rd, m_exp.wr, m_exp.oe, m_exp.busy, m_exp.rv, m_exp.wd,
                 m_exp.dout, m_rd_data);
      end
    end
    if (!cs && p_cs && !a_d) begin astb_cyc.push_back(cyc); astb_addr.push_back(dato_out); end
    if (!wr && p_wr && a_d) wstb_data.push_back(dato_out);
    if (rd_valid) rv_cyc.push_back(cyc);
    if (wr_done)  wd_cyc.push_back(cyc);
    p_cs = cs; p_wr = wr;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_logs();
    astb_cyc.delete(); astb_addr.delete(); wstb_data.delete(); rv_cyc.delete(); wd_cyc.delete();
  endtask

  task automatic do_reset(output int r);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    r = cyc;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1; @(negedge clk); rd_req = 1'b0;
  endtask

  task automatic pulse_wr();
    wr_req = 1'b1; @(negedge clk); wr_req = 1'b0;
  endtask

  initial begin
    int r, k, n;
    // Reset values
    do_reset(r);
    chk("rst_cs", cs, 1); chk("rst_rd", rd, 1); chk("rst_wr", wr, 1); chk("rst_ad", a_d, 1);
    chk("rst_oe", dato_oe, 0); chk("rst_busy", busy, 0); chk("rst_rd_data", rd_data, 0);

    // Read burst
    wait_to(r + 1); pulse_rd(); k = r + 2;
    wait_to(r + 33);
    chk("rd_astb_n", astb_addr.size(), 3);
    chk("rd_addr0", astb_addr[0], 8'h21); chk("rd_addr1", astb_addr[1], 8'h22); chk("rd_addr2", astb_addr[2], 8'h23);
    chk("rd_valid_cyc", rv_cyc[0], k + 28);
    chk("rd_data", rd_data, 24'h123045);

    // Reset during DATA_STB of a read
    wait_to(r + 35); pulse_rd(); k = cyc;
    wait_to(k + 5);
    chk("mid_in_data_stb", {cs, rd, a_d}, 3'b001);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("mid_strobes", {cs, rd, wr, a_d, dato_oe}, 5'b11110);
    chk("mid_busy", busy, 0); chk("mid_rv", rd_valid, 0); chk("mid_rd_data", rd_data, 0);
    clear_logs(); r = cyc;
    wait_to(r + 35);
    chk("mid_no_rv", rv_cyc.size(), 0);

    // Masked write burst
    do_reset(r);
    wr_data = 24'h591000; wr_mask = 3'b101;
    wait_to(r + 1); pulse_wr(); k = r + 2;
    wait_to(r + 24);
    chk("wr_astb_n", astb_addr.size(), 2);
    chk("wr_addr0", astb_addr[0], 8'h21); chk("wr_addr1", astb_addr[1], 8'h23);
    chk("wr_data0", wstb_data[0], 8'h00); chk("wr_data1", wstb_data[1], 8'h59);
    chk("wr_done_cyc", wd_cyc[0], k + 20);

    // Write request and refresh wrap in the same cycle
    do_reset(r);
    wait_to(r + 49); pulse_wr();
    wait_to(r + 101);
    chk("wrap_wr_done", wd_cyc[0], r + 70);
    chk("wrap_rd_astb", astb_cyc[2], r + 72);
    chk("wrap_rd_addr", astb_addr[2], 8'h21);
    chk("wrap_rv_cyc", rv_cyc[0], r + 99);

    // Two rd_req pulses during an active read collapse into one extra burst
    do_reset(r);
    wait_to(r + 1);  pulse_rd();
    wait_to(r + 9);  pulse_rd();
    wait_to(r + 14); pulse_rd();
    wait_to(r + 62);
    n = 0;
    foreach (rv_cyc[i]) if (rv_cyc[i] <= r + 60) n++;
    chk("dbl_rv_count", n, 2);
    chk("dbl_second_astb", astb_cyc[3], r + 32);
    chk("dbl_second_rv", rv_cyc[1], r + 59);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
